// File: rtl/fetch_pkg.sv
// Shared types and default sizes for the program sequencer and its branch LUT.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int PC_W_DEF  = 10;
  localparam int LUT_N_DEF = 16;
  localparam int LUT_IDX_W = $clog2(LUT_N_DEF);

endpackage

// File: rtl/branch_lut.sv
// Branch target table: one synchronous write port, one combinational read port.
module branch_lut
  import fetch_pkg::*;
#(
  parameter int PC_W  = PC_W_DEF,
  parameter int LUT_N = LUT_N_DEF,
  parameter int IDX_W = $clog2(LUT_N)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [PC_W-1:0]  wdata,
  input  logic [IDX_W-1:0] raddr,
  output logic [PC_W-1:0]  rdata
);

  logic [PC_W-1:0] mem [LUT_N];

  // NOTE: this array is reset entry by entry, so it maps to flops rather than
  // a RAM macro; acceptable at this size and required for a known table state.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < LUT_N; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // A read in the same cycle as a write to the same entry sees the old value.
  assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_ctrl.sv
// Program sequencer driving InstFetch: IDLE/RUN/DONE FSM, watchdog, branch
// target resolution and saturating cycle/branch counters.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int          PC_W       = PC_W_DEF,
  parameter int          LUT_N      = LUT_N_DEF,
  parameter logic [15:0] MAX_CYCLES = 16'd4096,
  parameter int          IDX_W      = $clog2(LUT_N)
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Go,
  input  logic             Halt,
  input  logic             StallReq,
  input  logic             BrEn,
  input  logic             BrCond,
  input  logic             BrRel,
  input  logic [IDX_W-1:0] BrIdx,
  input  logic [PC_W-1:0]  PC,
  input  logic             LutWe,
  input  logic [IDX_W-1:0] LutAddr,
  input  logic [PC_W-1:0]  LutData,
  output logic             Start,
  output logic             Branch,
  output logic [PC_W-1:0]  Target,
  output logic             Running,
  output logic             Done,
  output logic             Timeout,
  output logic [15:0]      CycleCount,
  output logic [7:0]       BranchCount
);

  state_t          state;
  logic [PC_W-1:0] lut_rd;
  logic            wd_hit;

  branch_lut #(
    .PC_W  (PC_W),
    .LUT_N (LUT_N),
    .IDX_W (IDX_W)
  ) u_lut (
    .clk   (Clk),
    .reset (Reset),
    .we    (LutWe),
    .waddr (LutAddr),
    .wdata (LutData),
    .raddr (BrIdx),
    .rdata (lut_rd)
  );

  assign wd_hit = (CycleCount == MAX_CYCLES - 16'd1);

  // InstFetch controls are combinational so decode reaches the PC with no delay.
  // NOTE: every output gets a default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    Start  = 1'b1;
    Branch = 1'b0;
    Target = '0;
    if (state == RUN && !Halt && !wd_hit && !StallReq) begin
      Start = 1'b0;
      if (BrEn && BrCond) begin
        Branch = 1'b1;
        Target = BrRel ? PC + lut_rd : lut_rd;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state       <= IDLE;
      Running     <= 1'b0;
      Done        <= 1'b0;
      Timeout     <= 1'b0;
      CycleCount  <= '0;
      BranchCount <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (Go) begin
            state   <= RUN;
            Running <= 1'b1;
          end
        end
        RUN: begin
          if (CycleCount != 16'hFFFF) CycleCount <= CycleCount + 16'd1;
          if (Halt) begin
            state   <= DONE;
            Running <= 1'b0;
            Done    <= 1'b1;
          end else if (wd_hit) begin
            state   <= DONE;
            Running <= 1'b0;
            Done    <= 1'b1;
            Timeout <= 1'b1;
          end else if (Branch && BranchCount != 8'hFF) begin
            BranchCount <= BranchCount + 8'd1;
          end
        end
        DONE: ;  // sticky until Reset
        default: begin
          state   <= IDLE;
          Running <= 1'b0;
          Done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with a behavioural InstFetch PC model per DUT.
module tb_fetch_ctrl;

  logic       clk = 1'b0;
  logic       reset, go, go_wd, halt, stall, br_en, br_cond, br_rel;
  logic [3:0] br_idx, lut_addr;
  logic       lut_we;
  logic [9:0] lut_data;

  logic [9:0]  pc, target, pc_wd, target_wd;
  logic        start, branch, running, done, timeout;
  logic        start_wd, branch_wd, running_wd, done_wd, timeout_wd;
  logic [15:0] cyc, cyc_wd;
  logic [7:0]  brc, brc_wd;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  fetch_ctrl dut (
    .Clk(clk), .Reset(reset), .Go(go), .Halt(halt), .StallReq(stall),
    .BrEn(br_en), .BrCond(br_cond), .BrRel(br_rel), .BrIdx(br_idx), .PC(pc),
    .LutWe(lut_we), .LutAddr(lut_addr), .LutData(lut_data),
    .Start(start), .Branch(branch), .Target(target), .Running(running),
    .Done(done), .Timeout(timeout), .CycleCount(cyc), .BranchCount(brc)
  );

  fetch_ctrl #(.MAX_CYCLES(16'd8)) dut_wd (
    .Clk(clk), .Reset(reset), .Go(go_wd), .Halt(halt), .StallReq(stall),
    .BrEn(br_en), .BrCond(br_cond), .BrRel(br_rel), .BrIdx(br_idx), .PC(pc_wd),
    .LutWe(lut_we), .LutAddr(lut_addr), .LutData(lut_data),
    .Start(start_wd), .Branch(branch_wd), .Target(target_wd), .Running(running_wd),
    .Done(done_wd), .Timeout(timeout_wd), .CycleCount(cyc_wd), .BranchCount(brc_wd)
  );

  // InstFetch behaviour: reset to 0, Start holds, Branch loads Target, else +1.
  always @(posedge clk) begin
    if (reset) pc <= '0;
    else if (start) pc <= pc;
    else if (branch) pc <= target;
    else pc <= pc + 10'd1;
  end

  always @(posedge clk) begin
    if (reset) pc_wd <= '0;
    else if (start_wd) pc_wd <= pc_wd;
    else if (branch_wd) pc_wd <= target_wd;
    else pc_wd <= pc_wd + 10'd1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_br();
    br_en = 0; br_cond = 0; br_rel = 0; br_idx = 0; halt = 0; stall = 0; lut_we = 0;
  endtask

  initial begin
    reset = 1; go = 0; go_wd = 0; lut_addr = 0; lut_data = 0;
    clear_br();
    tick(); tick();

    // Reset state
    check("rst_start", start, 1);
    check("rst_branch", branch, 0);
    check("rst_target", target, 0);
    check("rst_running", running, 0);
    check("rst_done", done, 0);
    check("rst_timeout", timeout, 0);
    check("rst_cyc", cyc, 0);
    check("rst_brc", brc, 0);

    // Go pulse, straight-line run: PC 0,0,1,2,3,4
    reset = 0; go = 1;
    check("pc_idle", pc, 0);
    tick(); go = 0;
    check("running", running, 1);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("pc_seq%0d", i), pc, i);
      tick();
    end
    check("cyc5", cyc, 5);
    check("pc5", pc, 5);

    // Program LUT[3]=008 and LUT[2]=3FE while running
    lut_we = 1; lut_addr = 3; lut_data = 10'h008; tick();
    lut_addr = 2; lut_data = 10'h3FE; tick();
    lut_we = 0;
    check("pc7", pc, 7);

    // Absolute branch via LUT[3]
    br_en = 1; br_cond = 1; br_rel = 0; br_idx = 3; #1;
    check("abs_branch", branch, 1);
    check("abs_target", target, 10'h008);
    tick();
    check("abs_pc", pc, 10'h008);
    check("abs_brc", brc, 1);

    // Branch and write to same index in one cycle uses the old entry (0)
    lut_we = 1; lut_addr = 4; lut_data = 10'h001; br_idx = 4; #1;
    check("wr_rd_target", target, 0);
    tick(); clear_br();
    check("wr_rd_pc", pc, 0);
    check("wr_rd_brc", brc, 2);
    tick();
    check("pc1", pc, 1);

    // Relative branch 1 + (-2) wraps to 3FF
    br_en = 1; br_cond = 1; br_rel = 1; br_idx = 2; #1;
    check("rel_target", target, 10'h3FF);
    tick();
    check("rel_pc", pc, 10'h3FF);
    check("rel_brc", brc, 3);

    // Same branch, condition false: increment (wraps to 0), target forced 0
    br_cond = 0; #1;
    check("nt_branch", branch, 0);
    check("nt_target", target, 0);
    tick(); clear_br();
    check("nt_pc", pc, 0);
    check("nt_brc", brc, 3);
    check("cyc12", cyc, 12);

    for (int i = 0; i < 5; i++) tick();
    check("pc_pre_stall", pc, 5);

    // Three stall cycles; the last also requests a branch that must lose
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) begin br_en = 1; br_cond = 1; br_idx = 3; end
      #1;
      check($sformatf("stall_start%0d", i), start, 1);
      check($sformatf("stall_branch%0d", i), branch, 0);
      tick();
      check($sformatf("stall_pc%0d", i), pc, 5);
    end
    check("stall_cyc", cyc, 20);
    check("stall_brc", brc, 3);

    // Halt with branch: halt wins
    stall = 0; halt = 1; br_en = 1; br_cond = 1; br_idx = 3; #1;
    check("halt_start", start, 1);
    check("halt_branch", branch, 0);
    tick(); clear_br();
    check("halt_done", done, 1);
    check("halt_running", running, 0);
    check("halt_timeout", timeout, 0);
    check("halt_pc", pc, 5);
    check("halt_brc", brc, 3);
    check("halt_cyc", cyc, 21);

    // DONE is sticky and ignores Go
    go = 1; tick(); tick(); go = 0;
    check("done_sticky", done, 1);
    check("done_pc", pc, 5);
    check("done_cyc", cyc, 21);

    // Watchdog instance, MAX_CYCLES = 8
    go_wd = 1; tick(); go_wd = 0;
    for (int i = 0; i < 7; i++) tick();
    check("wd_not_yet", done_wd, 0);
    br_en = 1; br_cond = 1; br_idx = 3; #1;
    check("wd_last_branch", branch_wd, 0);
    check("wd_last_start", start_wd, 1);
    tick(); clear_br();
    check("wd_done", done_wd, 1);
    check("wd_timeout", timeout_wd, 1);
    check("wd_pc", pc_wd, 7);
    check("wd_cyc", cyc_wd, 8);

    // Reset mid-RUN
    reset = 1; tick(); reset = 0;
    go = 1; tick(); go = 0;
    tick(); tick();
    check("mid_pc", pc, 2);
    reset = 1; tick(); reset = 0;
    check("mr_running", running, 0);
    check("mr_done", done, 0);
    check("mr_cyc", cyc, 0);
    check("mr_brc", brc, 0);
    check("mr_pc", pc, 0);
    go = 1; tick(); go = 0;
    br_en = 1; br_cond = 1; br_rel = 0; br_idx = 3; #1;
    check("mr_lut3", target, 0);
    check("mr_lut3_branch", branch, 1);
    tick(); clear_br();
    check("mr_branch_pc", pc, 0);
    check("mr_brc1", brc, 1);
    tick();
    check("mr_restart_pc", pc, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Program sequencer for the `InstFetch` unit. It owns InstFetch's `Start`, `Branch` and `Target` inputs, and runs a program from PC 0 until a halt instruction or a cycle watchdog expires. Branch targets come from a small writable lookup table (LUT) indexed by decode, either as absolute addresses or as PC-relative offsets. The block sits between decode and InstFetch, and exposes run status and cycle/branch counters to the testbench and top level.

## Interface
Parameters:
- `PC_W`, 10, program counter width (matches `ProgCtr`)
- `LUT_N`, 16, number of LUT entries (index width `$clog2(LUT_N)`)
- `MAX_CYCLES`, 16'd4096, watchdog limit in RUN cycles

Ports:
- `Clk`  in  1  clock; all state updates on the rising edge
- `Reset`  in  1  synchronous, active-high reset
- `Go`  in  1  start request, sampled only in IDLE
- `Halt`  in  1  decode saw a halt instruction
- `StallReq`  in  1  hold PC this cycle
- `BrEn`  in  1  decode saw a branch instruction
- `BrCond`  in  1  branch condition flag
- `BrRel`  in  1  1 = PC-relative (signed offset), 0 = absolute
- `BrIdx`  in  4  LUT index
- `PC`  in  PC_W  current `ProgCtr` from InstFetch
- `LutWe`  in  1  LUT write enable
- `LutAddr`  in  4  LUT write index
- `LutData`  in  PC_W  LUT write data
- `Start`  out  1  to InstFetch; 1 = hold PC
- `Branch`  out  1  to InstFetch; 1 = load `Target` at next edge
- `Target`  out  PC_W  to InstFetch
- `Running`  out  1  state == RUN
- `Done`  out  1  state == DONE
- `Timeout`  out  1  DONE was reached via the watchdog
- `CycleCount`  out  16  RUN cycles elapsed, saturating
- `BranchCount`  out  8  taken branches, saturating

## Operation
- InstFetch contract: on `Reset`, PC = 0. With `Start` high, PC is held. With `Branch` high, PC takes `Target`. Otherwise PC increments by 1.
- FSM states are IDLE, RUN and DONE.
- IDLE: `Start` = 1. `Go` = 1 moves the FSM to RUN.
- RUN: each cycle is resolved in this priority order:
  1. `Halt` → DONE, with `Start` = 1 this cycle.
  2. `CycleCount` == MAX_CYCLES−1 → DONE and `Timeout` set.
  3. `StallReq` → `Start` = 1, `Branch` = 0.
  4. `BrEn & BrCond` → `Branch` = 1, `BranchCount` +1.
  5. Otherwise `Start` = 0, `Branch` = 0 (PC increments).
- DONE: `Start` = 1. DONE is sticky until `Reset`; `Go` is ignored.
- `Start`, `Branch` and `Target` are combinational from the current state, inputs and LUT. This gives zero-cycle decode-to-InstFetch latency.
- `Target` = `LUT[BrIdx]` when `BrRel` = 0. When `BrRel` = 1, `Target` = `PC + LUT[BrIdx]` as a PC_W-bit two's-complement sum that wraps modulo 2^PC_W with no overflow flag.
- `Target` is driven to 0 whenever `Branch` = 0.
- LUT writes are accepted in any state. A branch in the same cycle as a write to the same index uses the old entry.
- `CycleCount` increments on every RUN cycle, including stall cycles and the Halt cycle. It saturates at FFFF and freezes in DONE.
- `BranchCount` saturates at FF.

## Timing
- Reset values: state IDLE, `Start` = 1, `Branch` = 0, `Target` = 0, `Running` = 0, `Done` = 0, `Timeout` = 0, both counters 0, all LUT entries 0.
- Reset asserted mid-RUN returns the block to IDLE at the next edge. The LUT is cleared as well.
- `Go` at edge N: `Running` = 1 from cycle N+1. The first PC increment happens at edge N+2.
- A taken branch in cycle K puts `Target` on `PC` after edge K.
- `Halt` at cycle K: `Done` = 1 after edge K. PC is never advanced past the halt instruction.
- `Halt` together with `BrEn` or `StallReq` in the same cycle: `Halt` wins and no branch is counted.
- Watchdog: `Done` and `Timeout` rise after the MAX_CYCLES-th RUN cycle. In that final cycle no branch is taken and PC is held.

## Structure
- Shared package `fetch_pkg` holds the FSM state enum, `PC_W`, and the LUT index width.
- LUT as a sub-module `branch_lut`: register array with one write port and one combinational read port, cleared on `Reset`.
- The FSM, counters and target adder live in `fetch_ctrl` and instantiate nothing else.
- The top level wires `fetch_ctrl` to InstFetch.

## Test plan
- Reset, then `Go` pulse, no branches, for 5 cycles → PC goes 0,0,1,2,3,4 and `CycleCount` = 5.
- Write LUT[3] = 10'h008. In RUN, assert `BrEn=1`, `BrCond=1`, `BrRel=0`, `BrIdx=3` for one cycle → next PC = 008 and `BranchCount` = 1.
- Write LUT[2] = 10'h3FE (−2). At PC = 001, take a relative branch → PC = 3FF (wrap). Then take the same branch with `BrCond=0` → PC increments and `BranchCount` is unchanged.
- Assert `StallReq` for 3 cycles at PC = 005 → PC stays 005 for 3 cycles and `CycleCount` still advances by 3. Assert `Halt` and `BrEn` together → `Done` = 1, PC frozen, `BranchCount` unchanged.
- Set MAX_CYCLES = 8 and run with no halt → `Done` = `Timeout` = 1 after 8 RUN cycles and PC = 007.
- Assert `Reset` mid-RUN → IDLE, counters 0, LUT[3] reads 0, and `Go` restarts from PC 0.
